hazard3_apb_arb_bridge: RTL and testbench

HAZARD3_APB_ARB_BRIDGE -- requirements
Module: hazard3_apb_arb_bridge

---
 rtl/hazard3_apb_arb_bridge.sv | 133 +++++++++++++
 tb/tb_hazard3_apb_arb_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_apb_arb_bridge.sv
// Round-robin arbiter bridging N_PORTS upstream APB requesters onto one downstream APB target.
// Define HAZARD3_APB_ARB_BRIDGE_TIMEOUT_EN to compile in the downstream wait timeout.
module hazard3_apb_arb_bridge #(
  parameter int N_PORTS        = 2,
  parameter int W_ADDR         = 8,
  parameter int W_DATA         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          src_psel,
  input  logic [N_PORTS-1:0]          src_penable,
  input  logic [N_PORTS-1:0]          src_pwrite,
  input  logic [N_PORTS*W_ADDR-1:0]   src_paddr,
  input  logic [N_PORTS*W_DATA-1:0]   src_pwdata,
  output logic [W_DATA-1:0]           src_prdata,
  output logic [N_PORTS-1:0]          src_pready,
  output logic                        src_pslverr,
  output logic                        dst_psel,
  output logic                        dst_penable,
  output logic                        dst_pwrite,
  output logic [W_ADDR-1:0]           dst_paddr,
  output logic [W_DATA-1:0]           dst_pwdata,
  input  logic [W_DATA-1:0]           dst_prdata,
  input  logic                        dst_pready,
  input  logic                        dst_pslverr
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, last_grant_q;
  logic                req_found;
  int                  req_idx;
  logic [W_ADDR-1:0]   addr_q;
  logic [W_DATA-1:0]   wdata_q;
  logic                write_q;
  logic [W_DATA-1:0]   rdata_q;
  logic                slverr_q;
  logic                tmo_hit;
  logic                unused_inputs;

  // Search upward from the port after the last one served, wrapping once.
  always_comb begin
    int cand;
    req_found = 1'b0;
    req_idx   = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = (int'(last_grant_q) + k) % N_PORTS;
      if (!req_found && src_psel[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

`ifdef HAZARD3_APB_ARB_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_IDLE && req_found) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !dst_pready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // A ready arriving on the expiry cycle still completes normally.
  assign tmo_hit = (state_q == S_ACCESS) && !dst_pready &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign unused_inputs = ^src_penable;
`else
  assign tmo_hit = 1'b0;
  assign unused_inputs = ^{src_penable, (TIMEOUT_CYCLES != 0)};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_found) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (dst_pready || tmo_hit) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_PORTS - 1);
      rdata_q      <= '0;
      slverr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_found) grant_q <= GW'(req_idx);
      if (state_q == S_ACCESS) begin
        if (dst_pready) begin
          rdata_q  <= dst_prdata;
          slverr_q <= dst_pslverr;
        end else if (tmo_hit) begin
          rdata_q  <= '0;
          slverr_q <= 1'b1;
        end
      end
      if (state_q == S_RESP) last_grant_q <= grant_q;
    end
  end

  // Request capture at grant; only meaningful while dst_psel is high.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_found) begin
      addr_q  <= src_paddr[req_idx*W_ADDR +: W_ADDR];
      wdata_q <= src_pwdata[req_idx*W_DATA +: W_DATA];
      write_q <= src_pwrite[req_idx];
    end
  end

  assign dst_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign dst_penable = (state_q == S_ACCESS);
  assign dst_paddr   = addr_q;
  assign dst_pwdata  = wdata_q;
  assign dst_pwrite  = write_q;
  assign src_pready  = (state_q == S_RESP) ? (N_PORTS'(1) << grant_q) : '0;
  assign src_prdata  = rdata_q;
  assign src_pslverr = slverr_q;

endmodule

// File: tb/tb_hazard3_apb_arb_bridge.sv
// Randomized bench for hazard3_apb_arb_bridge against a transaction-timeline reference model.
module tb_hazard3_apb_arb_bridge;
  localparam int N  = 4;
  localparam int WA = 8;
  localparam int WD = 32;
  localparam int TO = 4;
`ifdef HAZARD3_APB_ARB_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    src_psel, src_penable, src_pwrite;
  logic [N*WA-1:0] src_paddr;
  logic [N*WD-1:0] src_pwdata;
  logic [WD-1:0]   src_prdata;
  logic [N-1:0]    src_pready;
  logic            src_pslverr;
  logic            dst_psel, dst_penable, dst_pwrite;
  logic [WA-1:0]   dst_paddr;
  logic [WD-1:0]   dst_pwdata, dst_prdata;
  logic            dst_pready, dst_pslverr;

  hazard3_apb_arb_bridge #(
    .N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .src_psel(src_psel), .src_penable(src_penable), .src_pwrite(src_pwrite),
    .src_paddr(src_paddr), .src_pwdata(src_pwdata),
    .src_prdata(src_prdata), .src_pready(src_pready), .src_pslverr(src_pslverr),
    .dst_psel(dst_psel), .dst_penable(dst_penable), .dst_pwrite(dst_pwrite),
    .dst_paddr(dst_paddr), .dst_pwdata(dst_pwdata),
    .dst_prdata(dst_prdata), .dst_pready(dst_pready), .dst_pslverr(dst_pslverr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Upstream masters
  logic [N-1:0]  pend;
  logic [WA-1:0] m_addr [N];
  logic [WD-1:0] m_wdata [N];
  logic          m_wr [N];
  logic [N-1:0]  psel_prev;

  // Transaction-level model of the bridge timeline
  int            cyc;
  bit            busy;
  int            t_start, t_wait, t_acc, t_resp, free_at, last, g_port;
  logic [WA-1:0] g_addr;
  logic [WD-1:0] g_wdata, g_rdata;
  logic          g_wr, g_err;
  bit            g_to;
  int            served[$];

  // Knobs
  int            req_pct   = 0;
  bit            reissue   = 1'b0;
  int            fix_wait  = -1;
  int            fix_err   = -1;
  logic [WD-1:0] fix_rdata;
  bit            use_fix_rdata = 1'b0;
  int            max_wait  = 5;

  function automatic int pick(input logic [N-1:0] m, input int lst);
    for (int p = lst + 1; p < N; p++) if (m[p]) return p;
    for (int p = 0; p <= lst; p++) if (m[p]) return p;
    return -1;
  endfunction

  task automatic post_req(input int p, input logic wr, input logic [WA-1:0] a, input logic [WD-1:0] d);
    pend[p]    = 1'b1;
    m_wr[p]    = wr;
    m_addr[p]  = a;
    m_wdata[p] = d;
  endtask

  task automatic post_rand(input int p);
    post_req(p, 1'($urandom_range(0, 1)), WA'($urandom), $urandom);
  endtask

  task automatic apply();
    for (int p = 0; p < N; p++) begin
      src_psel[p]    = pend[p];
      src_penable[p] = 1'($urandom_range(0, 1));
      src_pwrite[p]  = pend[p] ? m_wr[p] : 1'($urandom_range(0, 1));
      src_paddr[p*WA +: WA]  = pend[p] ? m_addr[p] : WA'($urandom);
      src_pwdata[p*WD +: WD] = pend[p] ? m_wdata[p] : $urandom;
    end
    psel_prev = src_psel;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit in_xfer;
    int obs;
    @(negedge clk);
    cyc++;
    if (!busy && cyc >= free_at && psel_prev != '0) begin
      busy    = 1'b1;
      t_start = cyc;
      g_port  = pick(psel_prev, last);
      g_addr  = m_addr[g_port];
      g_wdata = m_wdata[g_port];
      g_wr    = m_wr[g_port];
      t_wait  = (fix_wait >= 0) ? fix_wait : $urandom_range(0, max_wait);
      g_rdata = use_fix_rdata ? fix_rdata : $urandom;
      g_err   = (fix_err >= 0) ? fix_err[0] : 1'($urandom_range(0, 1));
      g_to    = TO_EN && (t_wait + 1 > TO);
      t_acc   = g_to ? TO : t_wait + 1;
      t_resp  = t_start + 1 + t_acc;
    end
    in_xfer = busy && (cyc < t_resp);
    exp_rdy = '0;
    if (busy && cyc == t_resp) exp_rdy[g_port] = 1'b1;
    check_val("dst_psel", dst_psel, in_xfer);
    check_val("dst_penable", dst_penable, in_xfer && (cyc > t_start));
    check_val("src_pready", src_pready, exp_rdy);
    if (in_xfer) begin
      check_val("dst_paddr", dst_paddr, g_addr);
      check_val("dst_pwdata", dst_pwdata, g_wdata);
      check_val("dst_pwrite", dst_pwrite, g_wr);
    end
    if (busy && cyc == t_resp) begin
      check_val("src_prdata", src_prdata, g_to ? '0 : g_rdata);
      check_val("src_pslverr", src_pslverr, g_to ? 1'b1 : g_err);
      obs = -1;
      for (int p = 0; p < N; p++) if (src_pready[p]) obs = p;
      served.push_back(obs);
      last    = g_port;
      busy    = 1'b0;
      free_at = cyc + 2;
      pend[g_port] = 1'b0;
      if (reissue) post_rand(g_port);
    end
    if (busy && cyc == t_start + 1 + t_wait && !g_to) begin
      dst_pready  = 1'b1;
      dst_prdata  = g_rdata;
      dst_pslverr = g_err;
    end else begin
      dst_pready  = 1'b0;
      dst_prdata  = $urandom;
      dst_pslverr = 1'($urandom_range(0, 1));
    end
    for (int p = 0; p < N; p++)
      if (!pend[p] && $urandom_range(0, 99) < req_pct) post_rand(p);
    apply();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((pend != '0 || busy) && k < 300) begin
      cycle();
      k++;
    end
    check_val({tag, "_drain"}, (pend != '0) || busy, 1'b0);
    cycle();
  endtask

  task automatic wait_ready(input int p, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      cycle();
      if (src_pready[p]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_psel"}, dst_psel, 1'b0);
    check_val({tag, "_penable"}, dst_penable, 1'b0);
    check_val({tag, "_pready"}, src_pready, '0);
    check_val({tag, "_prdata"}, src_prdata, '0);
    check_val({tag, "_pslverr"}, src_pslverr, 1'b0);
  endtask

  task automatic reset_model();
    pend       = '0;
    busy       = 1'b0;
    last       = N - 1;
    dst_pready = 1'b0;
    apply();
  endtask

  initial begin
    int c0, at, s;
    rst = 1'b1;
    cyc = 0;
    dst_prdata  = '0;
    dst_pslverr = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    free_at = cyc + 1;
    cycle();

    // Single read from port 0, zero downstream wait
    fix_wait = 0; fix_err = 0; fix_rdata = 32'hDEADBEEF; use_fix_rdata = 1'b1;
    c0 = cyc;
    post_req(0, 1'b0, 8'h10, $urandom);
    apply();
    wait_ready(0, 20, at);
    check_val("lat_read", at - c0, 3);
    check_val("read_data", src_prdata, 32'hDEADBEEF);
    drain("read");

    // Write from port 1 with three wait states and slave error
    fix_wait = 3; fix_err = 1; fix_rdata = 32'h0;
    c0 = cyc;
    post_req(1, 1'b1, 8'h04, 32'hA5A5A5A5);
    apply();
    wait_ready(1, 30, at);
    check_val("lat_write", at - c0, 6);
    check_val("write_err", src_pslverr, 1'b1);
    drain("write");
    use_fix_rdata = 1'b0; fix_err = -1; fix_wait = -1;

    // Ports 0 and 1 requesting continuously must alternate
    s = served.size();
    post_rand(0); post_rand(1);
    apply();
    reissue = 1'b1;
    repeat (30) cycle();
    reissue = 1'b0;
    drain("alt");
    check_val("alt_count", served.size() - s >= 6, 1'b1);
    for (int k = s; k < served.size(); k++) check_val("alt_order", served[k], (k - s) % 2);

    // After port 2 is served, port 3 wins over port 1
    post_rand(2);
    apply();
    drain("p2");
    s = served.size();
    post_rand(1); post_rand(3);
    apply();
    drain("p13");
    check_val("rr_first", served[s], 3);
    check_val("rr_second", served[s+1], 1);

    // Long downstream stall: bus holds, or times out when the timeout is built in
    fix_wait = 12;
    post_rand(0);
    apply();
    drain("stall");
    fix_wait = -1;

    // Random traffic
    req_pct = 30; max_wait = 6;
    repeat (600) cycle();
    req_pct = 0;
    drain("rand");

    // Reset during ACCESS abandons the transfer
    fix_wait = 8;
    post_rand(2);
    apply();
    at = 0;
    while (!(busy && cyc > t_start) && at < 20) begin
      cycle();
      at++;
    end
    check_val("reach_access", dst_penable, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    reset_model();
    repeat (2) @(negedge clk);
    cyc += 2;
    rst = 1'b0;
    free_at = cyc + 1;
    fix_wait = -1;
    cycle();
    s = served.size();
    post_rand(3); post_rand(0);
    apply();
    drain("post_rst");
    check_val("post_rst_first", served[s], 0);
    check_val("post_rst_second", served[s+1], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
